// File: rtl/uart_reg_dump.sv
// Snapshot NUM_REGS registers on a strobe and stream them out as
// "<PFX><idx><SEP><hex>" lines over a valid/ready byte interface.
module uart_reg_dump #(
  parameter int         DATA_W   = 16,
  parameter int         NUM_REGS = 4,
  parameter logic [7:0] PFX_CHAR = 8'h52,
  parameter logic [7:0] SEP_CHAR = 8'h3A,
  parameter bit         EOL_CRLF = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_stb,
  input  logic [NUM_REGS*DATA_W-1:0]   i_data,
  input  logic [NUM_REGS-1:0]          i_mask,
  input  logic                         i_lz,
  output logic [7:0]                   o_byte,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_drop
);

  localparam int NIB = (DATA_W + 3) / 4;
  localparam int SW  = NIB * 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_PFX, S_IDX,
    S_SEP, S_NIB, S_CR, S_LF
  } state_t;

  state_t                       state_q, state_d;
  logic [NUM_REGS*DATA_W-1:0]   data_q, data_d;
  logic [NUM_REGS-1:0]          mask_q, mask_d;
  logic                         lz_q, lz_d;
  logic [SW-1:0]                shift_q, shift_d;
  logic [3:0]                   idx_q, idx_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         seen_q, seen_d;
  logic                         done_q, done_d;
  logic                         drop_q, drop_d;

  logic [3:0] top;
  logic       last;
  logic       skip;
  logic       acc;
  logic [7:0] byte_c;
  logic       valid_c;
  int         k;

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? 8'(8'h30 + n) : 8'(8'h37 + n);
  endfunction

  always_comb begin
    top  = shift_q[SW-1 -: 4];
    last = (cnt_q == CW'(NIB - 1));
    skip = (state_q == S_NIB) && lz_q && (top == 4'd0)
           && !last && !seen_q;
    k = 0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (mask_q[i]) k = i;
    end
    byte_c  = 8'h00;
    valid_c = 1'b0;
    case (state_q)
      S_PFX: begin byte_c = PFX_CHAR;   valid_c = 1'b1; end
      S_IDX: begin byte_c = hexc(idx_q); valid_c = 1'b1; end
      S_SEP: begin byte_c = SEP_CHAR;   valid_c = 1'b1; end
      S_NIB: begin byte_c = hexc(top);  valid_c = !skip; end
      S_CR:  begin byte_c = 8'h0D;      valid_c = 1'b1; end
      S_LF:  begin byte_c = 8'h0A;      valid_c = 1'b1; end
      default: ;
    endcase
    acc = valid_c && i_ready;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mask_d  = mask_q;
    lz_d    = lz_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    done_d  = 1'b0;
    // the done cycle still counts as busy for strobes
    drop_d  = i_stb && ((state_q != S_IDLE) || done_q);
    case (state_q)
      S_IDLE: if (i_stb && !done_q) begin
        data_d  = i_data;
        mask_d  = i_mask;
        lz_d    = i_lz;
        state_d = S_SCAN;
      end
      S_SCAN: if (|mask_q) begin
        shift_d   = SW'(data_q[k*DATA_W +: DATA_W]);
        idx_d     = 4'(k);
        mask_d[k] = 1'b0;
        cnt_d     = '0;
        seen_d    = 1'b0;
        state_d   = S_PFX;
      end else begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_PFX: if (acc) state_d = S_IDX;
      S_IDX: if (acc) state_d = S_SEP;
      S_SEP: if (acc) state_d = S_NIB;
      S_NIB: if (acc || skip) begin
        shift_d = shift_q << 4;
        seen_d  = seen_q || (top != 4'd0);
        if (!last) cnt_d = cnt_q + CW'(1);
        if (last) state_d = EOL_CRLF ? S_CR : S_LF;
      end
      S_CR:  if (acc) state_d = S_LF;
      S_LF:  if (acc) state_d = S_SCAN;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      mask_q  <= '0;
      lz_q    <= 1'b0;
      shift_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      lz_q    <= lz_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign o_byte  = byte_c;
  assign o_valid = valid_c;
  assign o_busy  = (state_q != S_IDLE);
  assign o_done  = done_q;
  assign o_drop  = drop_q;

endmodule

// File: tb/tb_uart_reg_dump.sv
// Randomised bench for uart_reg_dump: byte streams are compared
// against a string-level model of the dump format.
module tb_uart_reg_dump;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_stb;
  logic [63:0] i_data;
  logic [3:0]  i_mask;
  logic        i_lz;
  logic [7:0]  o_byte;
  logic        o_valid;
  logic        i_ready;
  logic        o_busy;
  logic        o_done;
  logic        o_drop;

  logic        stb_s;
  logic        lz_s;
  logic [0:0]  mask_s;
  logic [9:0]  data_b;
  logic [3:0]  data_c;
  logic [7:0]  byte_b, byte_c;
  logic        valid_b, valid_c, busy_b, busy_c;
  logic        dn_b, dn_c, dr_b, dr_c;

  int total = 0;
  int bad   = 0;

  bq_t got_a, got_b, got_c, exp_q;
  int  done_a = 0, drop_a = 0, done_b = 0, done_c = 0;
  bit  rnd_rdy = 0;
  bit  want_stall = 0;
  int  stall_left = 0;

  always #5 clk = ~clk;

  uart_reg_dump u_dut (
    .clk(clk), .rst_n(rst_n), .i_stb(i_stb), .i_data(i_data),
    .i_mask(i_mask), .i_lz(i_lz), .o_byte(o_byte),
    .o_valid(o_valid), .i_ready(i_ready), .o_busy(o_busy),
    .o_done(o_done), .o_drop(o_drop)
  );

  uart_reg_dump #(.DATA_W(10), .NUM_REGS(1), .EOL_CRLF(1'b0)) u_d10 (
    .clk(clk), .rst_n(rst_n), .i_stb(stb_s), .i_data(data_b),
    .i_mask(mask_s), .i_lz(lz_s), .o_byte(byte_b),
    .o_valid(valid_b), .i_ready(i_ready), .o_busy(busy_b),
    .o_done(dn_b), .o_drop(dr_b)
  );

  uart_reg_dump #(.DATA_W(4), .NUM_REGS(1), .EOL_CRLF(1'b0)) u_d4 (
    .clk(clk), .rst_n(rst_n), .i_stb(stb_s), .i_data(data_c),
    .i_mask(mask_s), .i_lz(lz_s), .o_byte(byte_c),
    .o_valid(valid_c), .i_ready(i_ready), .o_busy(busy_c),
    .o_done(dn_c), .o_drop(dr_c)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? 8'(8'h30 + n) : 8'(8'h37 + n);
  endfunction

  // One line of the dump: full-width hex, optionally stripped of
  // leading zeros but never down to an empty string.
  function automatic void add_line(input int k, input logic [63:0] v,
                                   input int dw, input bit z,
                                   input bit crlf);
    bq_t s;
    int nib = (dw + 3) / 4;
    for (int i = nib - 1; i >= 0; i--) s.push_back(hexc(4'(v >> (4 * i))));
    while (z && s.size() > 1 && s[0] == "0") void'(s.pop_front());
    exp_q.push_back("R");
    exp_q.push_back(hexc(4'(k)));
    exp_q.push_back(":");
    foreach (s[i]) exp_q.push_back(s[i]);
    if (crlf) exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  task automatic cmp_q(input string tag, input bq_t got, input bq_t exp);
    int n = (got.size() < exp.size()) ? got.size() : exp.size();
    chk({tag, "_len"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < n; i++) chk(tag, got[i], exp[i]);
  endtask

  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (stall_left > 0) begin
        i_ready = 1'b0;
        stall_left--;
      end else if (rnd_rdy) begin
        if (want_stall && got_a.size() == 5) begin
          want_stall = 0;
          stall_left = 19;
          i_ready    = 1'b0;
        end else begin
          i_ready = ($urandom % 3) != 0;
        end
      end else begin
        i_ready = 1'b1;
      end
    end
  end

  logic       pv = 1'b0, pr = 1'b1, pd = 1'b0;
  logic [7:0] pb = 8'h00;
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_valid && i_ready) got_a.push_back(o_byte);
      if (valid_b && i_ready) got_b.push_back(byte_b);
      if (valid_c && i_ready) got_c.push_back(byte_c);
      if (o_done) done_a++;
      if (o_drop) drop_a++;
      if (dn_b) done_b++;
      if (dn_c) done_c++;
      if (o_done) chk("done_pulse", 64'(pd), 0);
      if (pv && !pr) begin
        chk("hold_valid", 64'(o_valid), 1);
        chk("hold_byte", o_byte, pb);
      end
    end
    pv = rst_n && o_valid;
    pr = i_ready;
    pb = o_byte;
    pd = rst_n && o_done;
  end

  task automatic dump_a(input logic [63:0] d, input logic [3:0] m,
                        input bit z, input bit mid);
    int d0, p0;
    exp_q.delete();
    for (int k = 0; k < 4; k++)
      if (m[k]) add_line(k, 64'(d[k*16 +: 16]), 16, z, 1'b1);
    got_a.delete();
    d0 = done_a;
    p0 = drop_a;
    @(negedge clk);
    i_data = d; i_mask = m; i_lz = z; i_stb = 1'b1;
    @(posedge clk);
    #1;
    i_stb  = 1'b0;
    i_data = {$urandom, $urandom};
    i_mask = 4'($urandom);
    i_lz   = 1'($urandom);
    chk("busy_n1", 64'(o_busy), 1);
    chk("valid_n1", 64'(o_valid), 0);
    @(posedge clk);
    #1;
    if (m != 4'd0) begin
      chk("first_valid", 64'(o_valid), 1);
      chk("first_byte", o_byte, "R");
    end else begin
      chk("done_n2", 64'(o_done), 1);
      i_stb = 1'b1;
      @(posedge clk);
      #1;
      i_stb = 1'b0;
      chk("drop_donecyc", 64'(o_drop), 1);
      chk("idle_donecyc", 64'(o_busy), 0);
    end
    if (mid) begin
      repeat (4) @(negedge clk);
      i_data = {$urandom, $urandom};
      i_mask = 4'hF;
      i_stb  = 1'b1;
      @(negedge clk);
      i_stb = 1'b0;
    end
    for (int c = 0; c < 3000 && done_a == d0; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("done_once", 64'(done_a - d0), 1);
    if (mid) chk("drop_mid", 64'(drop_a - p0), 1);
    cmp_q("stream", got_a, exp_q);
  endtask

  task automatic dump_s(input logic [9:0] db, input logic [3:0] dc,
                        input bit z);
    bq_t eb;
    int  b0 = done_b;
    int  c0 = done_c;
    exp_q.delete();
    add_line(0, 64'(db), 10, z, 1'b0);
    eb = exp_q;
    exp_q.delete();
    add_line(0, 64'(dc), 4, z, 1'b0);
    got_b.delete();
    got_c.delete();
    @(negedge clk);
    data_b = db; data_c = dc; lz_s = z; stb_s = 1'b1;
    @(negedge clk);
    stb_s = 1'b0;
    for (int c = 0; c < 2000 && (done_b == b0 || done_c == c0); c++)
      @(negedge clk);
    repeat (3) @(negedge clk);
    chk("s10_done", 64'(done_b - b0), 1);
    chk("s4_done", 64'(done_c - c0), 1);
    cmp_q("s10", got_b, eb);
    cmp_q("s4", got_c, exp_q);
  endtask

  localparam logic [63:0] DREF = 64'hBEEF_0000_00A5_1234;

  initial begin
    logic [63:0] d;
    logic [3:0]  m;
    int          d0;
    rst_n = 1'b0; i_stb = 1'b0; i_data = '0; i_mask = '0; i_lz = 1'b0;
    stb_s = 1'b0; lz_s = 1'b0; mask_s = 1'b1; data_b = '0; data_c = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(o_valid), 0);
    chk("rst_busy", 64'(o_busy), 0);
    chk("rst_done", 64'(o_done), 0);
    chk("rst_drop", 64'(o_drop), 0);
    chk("rst_byte", o_byte, 0);
    rst_n = 1'b1;
    @(negedge clk);

    dump_a(DREF, 4'b1011, 1'b0, 1'b0);
    dump_a(DREF, 4'b0110, 1'b1, 1'b0);
    dump_a(DREF, 4'b0000, 1'b0, 1'b0);
    rnd_rdy    = 1;
    want_stall = 1;
    dump_a(DREF, 4'b1011, 1'b0, 1'b1);
    for (int t = 0; t < 20; t++) begin
      for (int n = 0; n < 16; n++)
        d[n*4 +: 4] = ($urandom % 3 == 0) ? 4'd0 : 4'($urandom);
      m = 4'($urandom);
      dump_a(d, m, 1'($urandom), (m != 4'd0) && (t % 3 == 0));
    end

    rnd_rdy = 0;
    repeat (3) @(negedge clk);
    got_a.delete();
    d0 = done_a;
    @(negedge clk);
    i_data = DREF; i_mask = 4'b1011; i_lz = 1'b0; i_stb = 1'b1;
    @(posedge clk);
    #1;
    i_stb = 1'b0;
    for (int c = 0; c < 200 && got_a.size() < 13; c++) @(negedge clk);
    chk("rst_reach", 64'(got_a.size() >= 13), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(o_valid), 0);
    chk("arst_busy", 64'(o_busy), 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("arst_nodone", 64'(done_a - d0), 0);
    dump_a(DREF, 4'b1111, 1'b0, 1'b0);

    dump_s(10'h3FF, 4'h0, 1'b1);
    dump_s(10'h000, 4'hA, 1'b0);
    rnd_rdy = 1;
    for (int t = 0; t < 4; t++)
      dump_s(10'($urandom % 64), 4'($urandom), 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
